speed_param_ctrl: RTL and testbench

//  Upstream control stage for the N-divider clock generator. Turns raw key inputs
//  (faster / slower / default) into the 32-bit speed_param word that stretches the

---
 rtl/speed_param_ctrl.sv | 147 ++++++++++++++
 tb/tb_speed_param_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_param_ctrl.sv
// rtl/speed_param_ctrl.sv - key-driven speed_param generator with debounce, hold-to-repeat and saturation
module speed_param_ctrl #(
  parameter logic [31:0] DEFAULT_PARAM   = 32'd0,
  parameter logic [31:0] MAX_PARAM       = 32'd1000,
  parameter logic [31:0] STEP            = 32'd1,
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500000,
  parameter logic [31:0] REPEAT_DELAY    = 32'd25000000,
  parameter logic [31:0] REPEAT_PERIOD   = 32'd5000000
) (
  input  logic        inclk,
  input  logic        reset,
  input  logic        key_faster,
  input  logic        key_slower,
  input  logic        key_default,
  output logic [31:0] speed_param,
  output logic        change_pulse,
  output logic        at_min,
  output logic        at_max
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HOLD,
    S_REPEAT
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [1:0]  r_kcap;
  logic        r_fast_s1, r_fast_s2;
  logic        r_slow_s1, r_slow_s2;
  logic        r_def_s1, r_def_s2, r_def_d;
  logic [31:0] r_param;
  logic        r_pulse;
  logic        r_at_min;
  logic        r_at_max;

  logic [1:0]  w_k;
  logic        w_same;
  logic        w_step;
  logic        w_def_rise;
  logic [31:0] w_next;

  always_comb begin
    w_k        = {r_fast_s2, r_slow_s2};
    w_same     = (w_k == r_kcap);
    w_def_rise = r_def_s2 & ~r_def_d;
    w_step     = 1'b0;
    case (r_state)
      S_DEBOUNCE: w_step = w_same && (r_cnt == DEBOUNCE_CYCLES - 32'd1);
      S_HOLD:     w_step = w_same && (r_cnt == REPEAT_DELAY - 32'd1);
      S_REPEAT:   w_step = w_same && (r_cnt == REPEAT_PERIOD - 32'd1);
      default:    w_step = 1'b0;
    endcase

    // Default load wins over a coincident step; both-keys capture never moves the value.
    w_next = r_param;
    if (w_def_rise) begin
      w_next = DEFAULT_PARAM;
    end else if (w_step) begin
      case (r_kcap)
        2'b10:   w_next = (r_param < STEP) ? 32'd0 : r_param - STEP;
        2'b01:   w_next = (r_param > MAX_PARAM - STEP) ? MAX_PARAM : r_param + STEP;
        default: w_next = r_param;
      endcase
    end
  end

  always_ff @(posedge inclk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 32'd0;
      r_kcap    <= 2'b00;
      r_fast_s1 <= 1'b0;
      r_fast_s2 <= 1'b0;
      r_slow_s1 <= 1'b0;
      r_slow_s2 <= 1'b0;
      r_def_s1  <= 1'b0;
      r_def_s2  <= 1'b0;
      r_def_d   <= 1'b0;
      r_param   <= DEFAULT_PARAM;
      r_pulse   <= 1'b0;
      r_at_min  <= (DEFAULT_PARAM == 32'd0);
      r_at_max  <= (DEFAULT_PARAM == MAX_PARAM);
    end else begin
      r_fast_s1 <= key_faster;
      r_fast_s2 <= r_fast_s1;
      r_slow_s1 <= key_slower;
      r_slow_s2 <= r_slow_s1;
      r_def_s1  <= key_default;
      r_def_s2  <= r_def_s1;
      r_def_d   <= r_def_s2;

      r_param   <= w_next;
      r_pulse   <= (w_next != r_param);
      r_at_min  <= (w_next == 32'd0);
      r_at_max  <= (w_next == MAX_PARAM);

      case (r_state)
        S_IDLE: begin
          if (w_k != 2'b00) begin
            r_state <= S_DEBOUNCE;
            r_kcap  <= w_k;
            r_cnt   <= 32'd0;
          end
        end
        S_DEBOUNCE: begin
          if (!w_same) begin
            r_state <= S_IDLE;
          end else if (w_step) begin
            r_state <= S_HOLD;
            r_cnt   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_HOLD: begin
          if (!w_same) begin
            r_state <= S_IDLE;
          end else if (w_step) begin
            r_state <= S_REPEAT;
            r_cnt   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_REPEAT: begin
          if (!w_same) begin
            r_state <= S_IDLE;
          end else if (w_step) begin
            r_cnt <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign speed_param  = r_param;
  assign change_pulse = r_pulse;
  assign at_min       = r_at_min;
  assign at_max       = r_at_max;

endmodule

// File: tb/tb_speed_param_ctrl.sv
// tb/tb_speed_param_ctrl.sv - randomized and directed self-checking bench for speed_param_ctrl
module tb_speed_param_ctrl;

  localparam int DEF = 5;
  localparam int MAXP = 10;
  localparam int STP = 1;
  localparam int DEB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic        inclk = 1'b0;
  logic        reset = 1'b1;
  logic        key_faster = 1'b0;
  logic        key_slower = 1'b0;
  logic        key_default = 1'b0;
  logic [31:0] speed_param;
  logic        change_pulse;
  logic        at_min;
  logic        at_max;

  int n_checks = 0;
  int n_fail = 0;

  speed_param_ctrl #(
    .DEFAULT_PARAM(32'(DEF)),
    .MAX_PARAM(32'(MAXP)),
    .STEP(32'(STP)),
    .DEBOUNCE_CYCLES(32'(DEB)),
    .REPEAT_DELAY(32'(RD)),
    .REPEAT_PERIOD(32'(RP))
  ) dut (
    .inclk(inclk),
    .reset(reset),
    .key_faster(key_faster),
    .key_slower(key_slower),
    .key_default(key_default),
    .speed_param(speed_param),
    .change_pulse(change_pulse),
    .at_min(at_min),
    .at_max(at_max)
  );

  always #5 inclk = ~inclk;

  // Reference model: a step fires when a captured key pattern has been held
  // DEB, DEB+RD, DEB+RD+n*RP edges after the edge at which it was captured.
  longint m_param = DEF;
  logic   m_pulse = 1'b0;
  logic   m_min = 1'b0;
  logic   m_max = 1'b0;
  logic [1:0] m_fhist = 2'b00, m_shist = 2'b00, m_dhist = 2'b00;
  logic   m_dprev = 1'b0;
  logic   m_active = 1'b0;
  logic [1:0] m_cap = 2'b00;
  longint m_edge = 0;
  longint m_start = 0;

  task automatic model_edge(input logic f, input logic s, input logic d, input logic r);
    logic [1:0] k;
    logic       rise;
    logic       step;
    longint     el;
    longint     nv;
    m_edge++;
    if (r) begin
      m_param = DEF; m_pulse = 1'b0;
      m_min = (DEF == 0); m_max = (DEF == MAXP);
      m_fhist = 2'b00; m_shist = 2'b00; m_dhist = 2'b00; m_dprev = 1'b0;
      m_active = 1'b0;
      return;
    end
    k    = {m_fhist[1], m_shist[1]};
    rise = m_dhist[1] & ~m_dprev;
    m_dprev = m_dhist[1];
    m_fhist = {m_fhist[0], f};
    m_shist = {m_shist[0], s};
    m_dhist = {m_dhist[0], d};
    step = 1'b0;
    if (!m_active) begin
      if (k != 2'b00) begin
        m_active = 1'b1; m_cap = k; m_start = m_edge;
      end
    end else if (k != m_cap) begin
      m_active = 1'b0;
    end else begin
      el = m_edge - m_start;
      step = (el == DEB) || (el == DEB + RD) ||
             ((el > DEB + RD) && ((el - DEB - RD) % RP == 0));
    end
    nv = m_param;
    if (rise) nv = DEF;
    else if (step && m_cap == 2'b10) nv = (m_param - STP < 0) ? 0 : m_param - STP;
    else if (step && m_cap == 2'b01) nv = (m_param + STP > MAXP) ? MAXP : m_param + STP;
    m_pulse = (nv != m_param);
    m_param = nv;
    m_min = (nv == 0);
    m_max = (nv == MAXP);
  endtask

  task automatic tick(input logic f, input logic s, input logic d, input logic r);
    key_faster = f; key_slower = s; key_default = d; reset = r;
    @(posedge inclk);
    model_edge(f, s, d, r);
    #1;
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (speed_param !== 32'(DEF) || change_pulse !== 1'b0 || at_min !== 1'b0 || at_max !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got p=%0d pulse=%b min=%b max=%b want p=%0d pulse=0 min=0 max=0",
               speed_param, change_pulse, at_min, at_max, DEF);
    end
  endtask

  task automatic test_single_step();
    int pulses = 0;
    int step_edge = -1;
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      tick(0, (e <= 6), 0, 0);
      if (change_pulse === 1'b1) begin pulses++; if (step_edge < 0) step_edge = e; end
      n_checks++;
      if (speed_param !== 32'(m_param) || change_pulse !== m_pulse) begin
        n_fail++;
        $display("FAIL single_step e=%0d: got p=%0d pulse=%b want p=%0d pulse=%b",
                 e, speed_param, change_pulse, m_param, m_pulse);
      end
    end
    n_checks++;
    if (speed_param !== 32'd6 || pulses != 1 || step_edge != DEB + 3) begin
      n_fail++;
      $display("FAIL single_step_sum: got p=%0d pulses=%0d edge=%0d want p=6 pulses=1 edge=%0d",
               speed_param, pulses, step_edge, DEB + 3);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    do_reset();
    for (int g = 0; g < 3; g++) begin
      for (int e = 0; e < 6; e++) begin
        tick(0, (e < 2), 0, 0);
        if (change_pulse === 1'b1) pulses++;
      end
    end
    n_checks++;
    if (speed_param !== 32'(DEF) || pulses != 0) begin
      n_fail++;
      $display("FAIL glitch: got p=%0d pulses=%0d want p=%0d pulses=0", speed_param, pulses, DEF);
    end
  endtask

  task automatic test_saturate_max();
    int exp_edges[5] = '{7, 15, 18, 21, 24};
    int got_edges[$];
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      tick(0, 1, 0, 0);
      if (change_pulse === 1'b1) got_edges.push_back(e);
      n_checks++;
      if (speed_param !== 32'(m_param) || change_pulse !== m_pulse || at_max !== m_max) begin
        n_fail++;
        $display("FAIL sat_max e=%0d: got p=%0d pulse=%b max=%b want p=%0d pulse=%b max=%b",
                 e, speed_param, change_pulse, at_max, m_param, m_pulse, m_max);
      end
    end
    n_checks++;
    if (got_edges.size() != 5 || speed_param !== 32'(MAXP) || at_max !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_max_sum: got npulse=%0d p=%0d max=%b want npulse=5 p=%0d max=1",
               got_edges.size(), speed_param, at_max, MAXP);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (got_edges[i] != exp_edges[i]) begin
          n_fail++;
          $display("FAIL step_edge[%0d]: got %0d want %0d", i, got_edges[i], exp_edges[i]);
        end
      end
    end
    for (int e = 0; e < 4; e++) tick(0, 0, 0, 0);
  endtask

  task automatic test_saturate_min();
    for (int e = 1; e <= 60; e++) begin
      tick(1, 0, 0, 0);
      n_checks++;
      if (speed_param !== 32'(m_param) || change_pulse !== m_pulse || at_min !== m_min) begin
        n_fail++;
        $display("FAIL sat_min e=%0d: got p=%0d pulse=%b min=%b want p=%0d pulse=%b min=%b",
                 e, speed_param, change_pulse, at_min, m_param, m_pulse, m_min);
      end
    end
    n_checks++;
    if (speed_param !== 32'd0 || at_min !== 1'b1 || at_max !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_min_sum: got p=%0d min=%b max=%b want p=0 min=1 max=0",
               speed_param, at_min, at_max);
    end
    for (int e = 0; e < 4; e++) tick(0, 0, 0, 0);
  endtask

  task automatic test_both_keys();
    int pulses = 0;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      tick(1, 1, 0, 0);
      if (change_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (speed_param !== 32'(DEF) || pulses != 0) begin
      n_fail++;
      $display("FAIL both_keys: got p=%0d pulses=%0d want p=%0d pulses=0", speed_param, pulses, DEF);
    end
    for (int e = 0; e < 4; e++) tick(0, 0, 0, 0);
  endtask

  task automatic test_default_and_reset();
    do_reset();
    for (int e = 1; e <= 25; e++) begin
      tick(0, 1, (e == 19), 0);
      if (e == 18) begin
        n_checks++;
        if (speed_param !== 32'd8) begin
          n_fail++;
          $display("FAIL pre_default: got p=%0d want p=8", speed_param);
        end
      end
      if (e == 21) begin
        n_checks++;
        if (speed_param !== 32'(DEF) || change_pulse !== 1'b1) begin
          n_fail++;
          $display("FAIL default_load: got p=%0d pulse=%b want p=%0d pulse=1",
                   speed_param, change_pulse, DEF);
        end
      end
      if (e == 24) begin
        n_checks++;
        if (speed_param !== 32'(DEF + 1) || change_pulse !== 1'b1) begin
          n_fail++;
          $display("FAIL repeat_after_default: got p=%0d pulse=%b want p=%0d pulse=1",
                   speed_param, change_pulse, DEF + 1);
        end
      end
    end
    tick(0, 1, 0, 1);
    n_checks++;
    if (speed_param !== 32'(DEF) || change_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got p=%0d pulse=%b want p=%0d pulse=0", speed_param, change_pulse, DEF);
    end
    for (int e = 1; e <= 12; e++) begin
      tick(0, 1, 0, 0);
      n_checks++;
      if (speed_param !== 32'(m_param) || change_pulse !== m_pulse) begin
        n_fail++;
        $display("FAIL post_reset e=%0d: got p=%0d pulse=%b want p=%0d pulse=%b",
                 e, speed_param, change_pulse, m_param, m_pulse);
      end
    end
    for (int e = 0; e < 4; e++) tick(0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic f, s, d, r;
    int   run;
    do_reset();
    for (int blk = 0; blk < 120; blk++) begin
      f = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      run = $urandom_range(1, 25);
      for (int e = 0; e < run; e++) begin
        d = ($urandom_range(0, 29) == 0);
        r = ($urandom_range(0, 299) == 0);
        tick(f, s, d, r);
        n_checks++;
        if (speed_param !== 32'(m_param) || change_pulse !== m_pulse ||
            at_min !== m_min || at_max !== m_max) begin
          n_fail++;
          $display("FAIL random blk=%0d: got p=%0d pulse=%b min=%b max=%b want p=%0d pulse=%b min=%b max=%b",
                   blk, speed_param, change_pulse, at_min, at_max, m_param, m_pulse, m_min, m_max);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_glitch();
    test_saturate_max();
    test_saturate_min();
    test_both_keys();
    test_default_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
